// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Produces hundreds/tens/ones digits held stable between conversions.
module bin_to_bcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shreg;
  logic [11:0]      scratch;
  logic [11:0]      adjusted;
  logic [11:0]      scratch_next;
  logic [CW-1:0]    count;
  logic             last_iter;

  function automatic logic [3:0] add3(input logic [3:0] n);
    if (n >= 4'd5) begin
      return n + 4'd3;
    end
    return n;
  endfunction

  // Each nibble is corrected on its own before the joint left shift.
  always_comb begin
    adjusted = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
  end

  assign scratch_next = (adjusted << 1) | {11'd0, shreg[WIDTH-1]};
  assign last_iter    = (count == LAST);
  assign busy         = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_iter) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Digits are written only on the final iteration, straight from the
  // post-shift scratch value, so the display never sees partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      scratch  <= '0;
      count    <= '0;
      done     <= 1'b0;
      ones     <= 4'd0;
      tens     <= 4'd0;
      hundreds <= 4'd0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          shreg   <= bin;
          scratch <= '0;
          count   <= '0;
        end
      end else begin
        shreg   <= shreg << 1;
        scratch <= scratch_next;
        count   <= count + 1'b1;
        if (last_iter) begin
          hundreds <= scratch_next[11:8];
          tens     <= scratch_next[7:4];
          ones     <= scratch_next[3:0];
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=8 and WIDTH=9 instances).
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start;
  logic [7:0] bin;
  logic       busy, done;
  logic [3:0] ones, tens, hundreds;
  logic       start9;
  logic [8:0] bin9;
  logic       busy9, done9;
  logic [3:0] ones9, tens9, hundreds9;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_h, exp_t, exp_o;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .ones(ones), .tens(tens), .hundreds(hundreds)
  );

  bin_to_bcd_seq #(.WIDTH(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start9), .bin(bin9),
    .busy(busy9), .done(done9), .ones(ones9), .tens(tens9), .hundreds(hundreds9)
  );

  task automatic test_reset();
    start = 1'b0; bin = '0; start9 = 1'b0; bin9 = '0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, hundreds, tens, ones} !== 14'd0) begin
      bad++;
      $display("[TB] FAIL reset_async: got %h want 0", {busy, done, hundreds, tens, ones});
    end
    total++;
    if ({busy9, done9, hundreds9, tens9, ones9} !== 14'd0) begin
      bad++;
      $display("[TB] FAIL reset_async9: got %h want 0", {busy9, done9, hundreds9, tens9, ones9});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, hundreds, tens, ones} !== 14'd0) begin
        bad++;
        $display("[TB] FAIL idle_hold cycle %0d: got %h want 0", i, {busy, done, hundreds, tens, ones});
      end
    end
    exp_h = 0; exp_t = 0; exp_o = 0;
  endtask

  task automatic test_single();
    int vals[5] = '{255, 0, 100, 199, 9};
    logic [3:0] eh[5] = '{4'd2, 4'd0, 4'd1, 4'd1, 4'd0};
    logic [3:0] et[5] = '{4'd5, 4'd0, 4'd0, 4'd9, 4'd0};
    logic [3:0] eo[5] = '{4'd5, 4'd0, 4'd0, 4'd9, 4'd9};
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      start = 1'b1; bin = 8'(vals[n]);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("[TB] FAIL single_busy v=%0d cycle %0d: got busy=%b done=%b want busy=1 done=0", vals[n], i, busy, done);
        end
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b1) begin
        bad++;
        $display("[TB] FAIL single_done v=%0d: got busy=%b done=%b want busy=0 done=1", vals[n], busy, done);
      end
      total++;
      if ({hundreds, tens, ones} !== {eh[n], et[n], eo[n]}) begin
        bad++;
        $display("[TB] FAIL single_digits v=%0d: got %h want %h", vals[n], {hundreds, tens, ones}, {eh[n], et[n], eo[n]});
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || {hundreds, tens, ones} !== {eh[n], et[n], eo[n]}) begin
        bad++;
        $display("[TB] FAIL single_after v=%0d: got done=%b digits=%h want done=0 digits=%h", vals[n], done, {hundreds, tens, ones}, {eh[n], et[n], eo[n]});
      end
      exp_h = eh[n]; exp_t = et[n]; exp_o = eo[n];
    end
  endtask

  task automatic test_back_to_back();
    int v = 0;
    int gap = 0;
    bit fin = 1'b0;
    logic [11:0] want;
    @(negedge clk);
    start = 1'b1; bin = 8'd0;
    for (int c = 0; c < 256 * 9 + 40 && !fin; c++) begin
      @(negedge clk);
      gap++;
      if (done === 1'b1) begin
        want = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        total++;
        if ({hundreds, tens, ones} !== want) begin
          bad++;
          $display("[TB] FAIL sweep_digits v=%0d: got %h want %h", v, {hundreds, tens, ones}, want);
        end
        total++;
        if (gap != 9) begin
          bad++;
          $display("[TB] FAIL sweep_period v=%0d: got %0d cycles want 9", v, gap);
        end
        exp_h = want[11:8]; exp_t = want[7:4]; exp_o = want[3:0];
        gap = 0;
        if (v == 255) begin
          start = 1'b0;
          fin = 1'b1;
        end else begin
          v++;
          bin = 8'(v);
        end
      end else begin
        total++;
        if ({hundreds, tens, ones} !== {exp_h, exp_t, exp_o}) begin
          bad++;
          $display("[TB] FAIL sweep_hold v=%0d: got %h want %h", v, {hundreds, tens, ones}, {exp_h, exp_t, exp_o});
        end
      end
    end
    total++;
    if (fin !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sweep_timeout: reached v=%0d want 255", v);
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    @(negedge clk);
    start = 1'b1; bin = 8'd42;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        start = 1'b1; bin = 8'd7;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) dones++;
      total++;
      if (busy !== (cyc <= 8) || done !== (cyc == 9)) begin
        bad++;
        $display("[TB] FAIL ignore_timing cycle %0d: got busy=%b done=%b want busy=%b done=%b", cyc, busy, done, cyc <= 8, cyc == 9);
      end
      if (cyc == 9) begin
        total++;
        if ({hundreds, tens, ones} !== 12'h042) begin
          bad++;
          $display("[TB] FAIL ignore_digits: got %h want 042", {hundreds, tens, ones});
        end
      end
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("[TB] FAIL ignore_done_count: got %0d want 1", dones);
    end
    exp_h = 0; exp_t = 4; exp_o = 2;
  endtask

  task automatic test_reset_midway();
    @(negedge clk);
    start = 1'b1; bin = 8'd123;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, hundreds, tens, ones} !== 14'd0) begin
      bad++;
      $display("[TB] FAIL midreset_async: got %h want 0", {busy, done, hundreds, tens, ones});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, hundreds, tens, ones} !== 14'd0) begin
        bad++;
        $display("[TB] FAIL midreset_quiet cycle %0d: got %h want 0", i, {busy, done, hundreds, tens, ones});
      end
    end
    start = 1'b1; bin = 8'd123;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midreset_rerun_busy cycle %0d: got busy=%b done=%b want 1/0", i, busy, done);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || {hundreds, tens, ones} !== 12'h123) begin
      bad++;
      $display("[TB] FAIL midreset_rerun: got done=%b digits=%h want done=1 digits=123", done, {hundreds, tens, ones});
    end
  endtask

  task automatic test_width9();
    int vals[2] = '{511, 300};
    logic [11:0] want[2] = '{12'h511, 12'h300};
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      start9 = 1'b1; bin9 = 9'(vals[n]);
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        start9 = 1'b0;
        total++;
        if (busy9 !== 1'b1 || done9 !== 1'b0) begin
          bad++;
          $display("[TB] FAIL w9_busy v=%0d cycle %0d: got busy=%b done=%b want 1/0", vals[n], i, busy9, done9);
        end
      end
      @(negedge clk);
      total++;
      if (busy9 !== 1'b0 || done9 !== 1'b1 || {hundreds9, tens9, ones9} !== want[n]) begin
        bad++;
        $display("[TB] FAIL w9_done v=%0d: got busy=%b done=%b digits=%h want 0/1/%h", vals[n], busy9, done9, {hundreds9, tens9, ones9}, want[n]);
      end
      @(negedge clk);
      total++;
      if (done9 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL w9_done_pulse v=%0d: got done=%b want 0", vals[n], done9);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_start();
    test_reset_midway();
    test_width9();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that produces the `ones`, `tens` and `hundreds` digits consumed by the timer seven-segment multiplexer. It accepts an unsigned binary value (an 8-bit processor register or counter value), runs a shift-and-add-3 (double-dabble) conversion one bit per clock, and holds the three resulting BCD digits stable until the next conversion completes. A start/busy/done handshake lets a counter or CPU output port request conversions without glitching the display.

## Interface
Parameters:
- `WIDTH`, default 8: binary input width. Legal range is 1..9, because the value must fit in three BCD digits (maximum 511).

Ports:
- `clk`  in  1: system clock, 100 MHz; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: conversion request. Sampled only in IDLE.
- `bin`  in  WIDTH: unsigned value. Sampled on the same edge that accepts `start`.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when new digits are valid.
- `ones`  out  4: BCD units digit (0..9).
- `tens`  out  4: BCD tens digit (0..9).
- `hundreds`  out  4: BCD hundreds digit (0..5 for WIDTH ≤ 9).

## Operation
- State machine has two states: IDLE and SHIFT.
- Internal registers:
  - shift register of WIDTH bits.
  - 12-bit scratch BCD register holding three nibbles.
  - iteration counter of ceil(log2(WIDTH+1)) bits.
- IDLE:
  - If `start` = 1, load `bin` into the shift register, clear scratch to 0, clear the counter, and go to SHIFT.
  - Otherwise hold.
- SHIFT, one iteration per cycle:
  - Each scratch nibble ≥ 5 gets +3 (nibbles evaluated independently, same cycle).
  - Then {scratch, shift register} shifts left by 1; the shift register MSB enters scratch bit 0.
  - Counter increments.
- Final iteration (counter == WIDTH-1):
  - The post-shift scratch value is written directly to `hundreds`/`tens`/`ones`.
  - `done` is set for one cycle and the state returns to IDLE.
- Outputs `ones`/`tens`/`hundreds` change only on the final-iteration edge or on reset. They hold their last result indefinitely otherwise.
- `busy` = 1 exactly when state is SHIFT; it is registered or state-decoded, with no combinational path from `start`.
- `start` while busy: ignored, not queued. `bin` changes during SHIFT have no effect.
- Add-3 arithmetic is 4-bit per nibble. No carry propagates between nibbles outside the shift.
- WIDTH = 1: a single SHIFT cycle, and the result equals `bin`.

## Timing
- Reset asserted (async): state = IDLE, `busy` = 0, `done` = 0, `ones` = `tens` = `hundreds` = 0, and scratch, shift register and counter are cleared. This holds immediately, without waiting for a clock.
- Reset mid-conversion: the conversion is aborted, no `done` is produced, and the digits read 0.
- Reset deassertion is synchronized externally. The block starts in IDLE on the first edge after release.
- Latency: `start` accepted at edge k → `busy` high after edge k.
- Edge k+WIDTH: `busy` low, `done` high, and digits valid, all in the same cycle.
- `done` falls after edge k+WIDTH+1 unless a new conversion completes there (impossible for WIDTH ≥ 1).
- Back-to-back: `start` held high is accepted at edge k+WIDTH+1 (the cycle `done` is high, state IDLE). Throughput is one conversion per WIDTH+1 cycles.
- The display multiplexer sees only registered digit changes, updated at most once per conversion.

## Test plan
- Reset then idle, WIDTH=8, no `start` → `busy` = 0, `done` = 0, digits 0/0/0 for 20 cycles.
- `bin` = 255, one-cycle `start` → `busy` for exactly 8 cycles, then `done` one cycle with `hundreds`=2, `tens`=5, `ones`=5. Repeat for 0 → 0/0/0, 100 → 1/0/0, 199 → 1/9/9, and 9 → 0/0/9.
- Exhaustive sweep of 0..255 with back-to-back `start` held high → each `done` shows digits equal to the decimal value, one `done` every 9 cycles, and the digits never change outside `done` edges.
- `start` with `bin` = 42, then pulse `start` with `bin` = 7 three cycles later → second request ignored, result 0/4/2, and no extra `done`.
- `bin` = 123, assert `rst_n` = 0 asynchronously at iteration 4 → digits and `busy` go 0 before the next clock edge, no `done`. After release, `start` with 123 → 1/2/3.
- WIDTH=9 instance, `bin` = 511 → `done` 9 cycles after accept, 5/1/1.
